// File: rtl/datapath_unit.sv
// Execution datapath: 16-entry register file, 16-function ALU, synchronous read-first
// data RAM and a registered {Z,N,C,V} flags register, driven by a per-cycle control word.
module datapath_unit #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned D_ADDR_W = 8,
    parameter int unsigned R_ADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                D_wr,
    input  logic                RF_s,
    input  logic                RF_W_en,
    input  logic [D_ADDR_W-1:0] D_addr,
    input  logic [R_ADDR_W-1:0] RF_W_addr,
    input  logic [R_ADDR_W-1:0] RF_A_addr,
    input  logic [R_ADDR_W-1:0] RF_B_addr,
    input  logic [3:0]          ALU_sel,
    output logic [WIDTH-1:0]    A_out,
    output logic [WIDTH-1:0]    B_out,
    output logic [WIDTH-1:0]    ALU_out,
    output logic [WIDTH-1:0]    Mem_out,
    output logic [3:0]          Flags
);

    localparam int unsigned NumRegs  = 1 << R_ADDR_W;
    localparam int unsigned MemDepth = 1 << D_ADDR_W;

    logic [WIDTH-1:0] rf_q  [NumRegs];
    logic [WIDTH-1:0] ram_q [MemDepth];
    logic [WIDTH-1:0] mem_out_q;
    logic [3:0]       flags_q;

    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] alu_res;
    logic             carry;
    logic             ovf;
    logic [WIDTH-1:0] rf_wdata;

    assign A_out   = rf_q[RF_A_addr];
    assign B_out   = rf_q[RF_B_addr];
    assign ALU_out = alu_res;
    assign Mem_out = mem_out_q;
    assign Flags   = flags_q;

    // All add/sub variants share one adder; subtraction is x + ~y + 1 so the carry-out
    // is directly the NOT-borrow flag.
    always_comb begin
        add_x   = A_out;
        add_y   = B_out;
        add_cin = 1'b0;
        case (ALU_sel)
            4'd2: begin
                add_y   = ~B_out;
                add_cin = 1'b1;
            end
            4'd7: begin
                add_y   = '0;
                add_cin = 1'b1;
            end
            4'd13: begin
                add_x   = B_out;
                add_y   = ~A_out;
                add_cin = 1'b1;
            end
            4'd14: add_y = '1;
            default: ;
        endcase
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

    always_comb begin
        alu_res = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        case (ALU_sel)
            4'd1, 4'd2, 4'd7, 4'd13, 4'd14: begin
                alu_res = add_sum[WIDTH-1:0];
                carry   = add_sum[WIDTH];
                ovf     = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != add_x[WIDTH-1]);
            end
            4'd3:  alu_res = A_out;
            4'd4:  alu_res = A_out ^ B_out;
            4'd5:  alu_res = A_out | B_out;
            4'd6:  alu_res = A_out & B_out;
            4'd8:  alu_res = B_out;
            4'd9:  alu_res = ~A_out;
            4'd10: {carry, alu_res} = {A_out, 1'b0};
            4'd11: begin
                alu_res = {1'b0, A_out[WIDTH-1:1]};
                carry   = A_out[0];
            end
            4'd12: begin
                alu_res = {A_out[WIDTH-1], A_out[WIDTH-1:1]};
                carry   = A_out[0];
            end
            default: alu_res = '0;
        endcase
    end

    assign rf_wdata = RF_s ? mem_out_q : alu_res;

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_q      <= '{default: '0};
            mem_out_q <= '0;
            flags_q   <= '0;
        end else begin
            if (RF_W_en) begin
                rf_q[RF_W_addr] <= rf_wdata;
            end
            mem_out_q <= ram_q[D_addr];
            if (RF_W_en && !RF_s) begin
                flags_q <= {(alu_res == '0), alu_res[WIDTH-1], carry, ovf};
            end
        end
    end

    // RAM contents survive reset; only the write is suppressed.
    always_ff @(posedge clk) begin
        if (D_wr && !reset) begin
            ram_q[D_addr] <= A_out;
        end
    end

endmodule

// File: tb/tb_datapath_unit.sv
// Scoreboard bench for datapath_unit: directed and random control words checked against
// an arithmetic reference model; a negedge monitor pops and compares expected outputs.
module tb_datapath_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        D_wr;
    logic        RF_s;
    logic        RF_W_en;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr;
    logic [3:0]  RF_A_addr;
    logic [3:0]  RF_B_addr;
    logic [3:0]  ALU_sel;
    logic [15:0] A_out;
    logic [15:0] B_out;
    logic [15:0] ALU_out;
    logic [15:0] Mem_out;
    logic [3:0]  Flags;

    always #5 clk = ~clk;

    datapath_unit dut (
        .clk      (clk),
        .reset    (reset),
        .D_wr     (D_wr),
        .RF_s     (RF_s),
        .RF_W_en  (RF_W_en),
        .D_addr   (D_addr),
        .RF_W_addr(RF_W_addr),
        .RF_A_addr(RF_A_addr),
        .RF_B_addr(RF_B_addr),
        .ALU_sel  (ALU_sel),
        .A_out    (A_out),
        .B_out    (B_out),
        .ALU_out  (ALU_out),
        .Mem_out  (Mem_out),
        .Flags    (Flags)
    );

    typedef struct packed {
        logic       rst;
        logic       d_wr;
        logic       rf_s;
        logic       w_en;
        logic [7:0] d_addr;
        logic [3:0] w;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sel;
    } ctl_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] alu;
        logic [15:0] mem;
        logic [3:0]  flags;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   chk_en  = 1'b0;

    logic [15:0] m_rf  [16];
    logic [15:0] m_ram [256];
    logic [15:0] m_mem;
    logic [3:0]  m_flags;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Reference ALU from integer arithmetic on unsigned and signed views of the operands.
    function automatic void alu_model(input logic [3:0] sel, input logic [15:0] a,
                                      input logic [15:0] b, output logic [15:0] r,
                                      output logic c, output logic v);
        int ua, ub, sa, sb, full, sfull;
        bit arith;
        logic signed [15:0] sg;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        full = 0; sfull = 0; arith = 1'b0;
        r = '0; c = 1'b0; v = 1'b0;
        case (sel)
            4'd1:  begin full = ua + ub; sfull = sa + sb; c = (full > 65535); arith = 1'b1; end
            4'd2:  begin full = ua - ub; sfull = sa - sb; c = (ua >= ub); arith = 1'b1; end
            4'd7:  begin full = ua + 1; sfull = sa + 1; c = (full > 65535); arith = 1'b1; end
            4'd13: begin full = ub - ua; sfull = sb - sa; c = (ub >= ua); arith = 1'b1; end
            4'd14: begin full = ua - 1; sfull = sa - 1; c = (ua >= 1); arith = 1'b1; end
            4'd3:  r = a;
            4'd4:  r = a ^ b;
            4'd5:  r = a | b;
            4'd6:  r = a & b;
            4'd8:  r = b;
            4'd9:  r = ~a;
            4'd10: begin r = a << 1; c = a[15]; end
            4'd11: begin r = a >> 1; c = a[0]; end
            4'd12: begin sg = a; r = sg >>> 1; c = a[0]; end
            default: r = '0;
        endcase
        if (arith) begin
            r = full[15:0];
            v = (sfull > 32767) || (sfull < -32768);
        end
    endfunction

    task automatic step(input ctl_t c);
        logic [15:0] ea, eb, r, nm;
        logic fc, fv;
        @(posedge clk);
        #1;
        reset     = c.rst;
        D_wr      = c.d_wr;
        RF_s      = c.rf_s;
        RF_W_en   = c.w_en;
        D_addr    = c.d_addr;
        RF_W_addr = c.w;
        RF_A_addr = c.a;
        RF_B_addr = c.b;
        ALU_sel   = c.sel;
        ea = m_rf[c.a];
        eb = m_rf[c.b];
        alu_model(c.sel, ea, eb, r, fc, fv);
        if (chk_en) sb_q.push_back('{a: ea, b: eb, alu: r, mem: m_mem, flags: m_flags});
        if (c.rst) begin
            foreach (m_rf[i]) m_rf[i] = '0;
            m_mem   = '0;
            m_flags = '0;
        end else begin
            nm = m_ram[c.d_addr];
            if (c.d_wr) m_ram[c.d_addr] = ea;
            if (c.w_en) m_rf[c.w] = c.rf_s ? m_mem : r;
            if (c.w_en && !c.rf_s) m_flags = {(r == 16'h0), r[15], fc, fv};
            m_mem = nm;
        end
    endtask

    task automatic op(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] w);
        ctl_t c;
        c = '0; c.sel = sel; c.a = a; c.b = b; c.w = w; c.w_en = 1'b1;
        step(c);
    endtask

    task automatic peek(input logic [3:0] a, input logic [3:0] b);
        ctl_t c;
        c = '0; c.a = a; c.b = b;
        step(c);
        #2;
    endtask

    task automatic store(input logic [3:0] r, input logic [7:0] addr);
        ctl_t c;
        c = '0; c.d_wr = 1'b1; c.a = r; c.d_addr = addr;
        step(c);
    endtask

    task automatic load(input logic [7:0] addr, input logic [3:0] r);
        ctl_t c;
        c = '0; c.d_addr = addr;
        step(c);
        c.rf_s = 1'b1; c.w_en = 1'b1; c.w = r;
        step(c);
    endtask

    // Shift-and-increment a constant into register r starting from zero.
    task automatic build(input logic [3:0] r, input logic [15:0] val);
        op(4'd0, r, r, r);
        for (int i = 15; i >= 0; i--) begin
            op(4'd10, r, r, r);
            if (val[i]) op(4'd7, r, r, r);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_a_out", A_out, e.a);
            check("sb_b_out", B_out, e.b);
            check("sb_alu_out", ALU_out, e.alu);
            check("sb_mem_out", Mem_out, e.mem);
            check("sb_flags", Flags, e.flags);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t c;
        foreach (m_ram[i]) m_ram[i] = '0;
        foreach (m_rf[i]) m_rf[i] = '0;
        m_mem = '0; m_flags = '0;
        reset = 1'b1; D_wr = 1'b0; RF_s = 1'b0; RF_W_en = 1'b0; D_addr = '0;
        RF_W_addr = '0; RF_A_addr = '0; RF_B_addr = '0; ALU_sel = '0;

        // Reset held with write enables asserted
        c = '0; c.rst = 1'b1;
        step(c);
        chk_en = 1'b1;
        c.w_en = 1'b1; c.d_wr = 1'b1; c.sel = 4'd7;
        step(c);
        step(c);
        peek(4'd0, 4'd15);
        check("rst_a_out", A_out, 16'h0000);
        check("rst_b_out", B_out, 16'h0000);
        check("rst_mem_out", Mem_out, 16'h0000);
        check("rst_flags", Flags, 4'h0);

        // Give the RAM known contents
        chk_en = 1'b0;
        for (int i = 0; i < 256; i++) store(4'd0, 8'(i));
        c = '0;
        step(c);
        chk_en = 1'b1;

        build(4'd8, 16'h0005); store(4'd8, 8'h10);
        build(4'd8, 16'h0003); store(4'd8, 8'h11);
        load(8'h10, 4'd1); load(8'h11, 4'd2);
        peek(4'd1, 4'd2);
        check("load_r1", A_out, 16'h0005);
        check("load_r2", B_out, 16'h0003);

        op(4'd1, 4'd1, 4'd2, 4'd3);
        peek(4'd3, 4'd0);
        check("add_r3", A_out, 16'h0008);
        check("add_flags", Flags, 4'b0000);

        op(4'd2, 4'd1, 4'd2, 4'd4);
        peek(4'd4, 4'd0);
        check("sub_r4", A_out, 16'h0002);
        check("sub_flags", Flags, 4'b0010);

        // Store then load with exact 2-edge latency; flags must hold through it
        build(4'd1, 16'h1234);
        op(4'd9, 4'd0, 4'd0, 4'd14);
        store(4'd1, 8'h20);
        c = '0; c.d_addr = 8'h20; c.a = 4'd5;
        step(c);
        c.rf_s = 1'b1; c.w_en = 1'b1; c.w = 4'd5;
        step(c);
        #2;
        check("load_r5_early", A_out, 16'h0000);
        peek(4'd5, 4'd0);
        check("load_r5", A_out, 16'h1234);
        check("load_flags_hold", Flags, 4'b0100);

        build(4'd6, 16'h7FFF);
        op(4'd7, 4'd6, 4'd6, 4'd9);
        peek(4'd9, 4'd0);
        check("inc_ovf_res", A_out, 16'h8000);
        check("inc_ovf_flags", Flags, 4'b0101);

        op(4'd9, 4'd0, 4'd0, 4'd7);
        op(4'd7, 4'd7, 4'd7, 4'd10);
        peek(4'd10, 4'd7);
        check("inc_wrap_res", A_out, 16'h0000);
        check("inc_wrap_src", B_out, 16'hFFFF);
        check("inc_wrap_flags", Flags, 4'b1010);

        // RF write-to-read: no bypass
        c = '0; c.sel = 4'd7; c.a = 4'd2; c.b = 4'd2; c.w = 4'd2; c.w_en = 1'b1;
        step(c);
        #2;
        check("rf_hazard_old", A_out, 16'h0003);
        check("rf_hazard_alu", ALU_out, 16'h0004);
        peek(4'd2, 4'd0);
        check("rf_hazard_new", A_out, 16'h0004);

        // RAM read-first on a same-address write
        c = '0; c.d_wr = 1'b1; c.d_addr = 8'h20; c.a = 4'd3;
        step(c);
        c = '0; c.d_addr = 8'h20;
        step(c);
        #2;
        check("ram_read_first", Mem_out, 16'h1234);
        step(c);
        #2;
        check("ram_new_word", Mem_out, 16'h0008);

        // Reset suppresses RF/RAM writes and leaves RAM contents intact
        build(4'd12, 16'hBEEF);
        store(4'd12, 8'h50);
        c = '0; c.rst = 1'b1; c.w_en = 1'b1; c.d_wr = 1'b1; c.d_addr = 8'h50;
        c.a = 4'd12; c.w = 4'd12; c.sel = 4'd7;
        step(c);
        step(c);
        peek(4'd12, 4'd0);
        check("rst2_r12", A_out, 16'h0000);
        check("rst2_flags", Flags, 4'h0);
        load(8'h50, 4'd13);
        peek(4'd13, 4'd0);
        check("ram_survives_rst", A_out, 16'hBEEF);

        // Reset in cycle 2 of a load
        c = '0; c.d_addr = 8'h20;
        step(c);
        c.rst = 1'b1; c.rf_s = 1'b1; c.w_en = 1'b1; c.w = 4'd11;
        step(c);
        peek(4'd11, 4'd0);
        check("midload_r11", A_out, 16'h0000);
        check("midload_mem", Mem_out, 16'h0000);

        for (int n = 0; n < 1500; n++) begin
            c.rst    = ($urandom_range(0, 63) == 0);
            c.d_wr   = 1'($urandom_range(0, 3) == 0);
            c.rf_s   = 1'($urandom);
            c.w_en   = 1'($urandom);
            c.d_addr = 8'($urandom_range(0, 15));
            c.w      = 4'($urandom);
            c.a      = 4'($urandom);
            c.b      = 4'($urandom);
            c.sel    = 4'($urandom);
            step(c);
        end

        peek(4'd0, 4'd0);
        peek(4'd0, 4'd0);
        @(negedge clk);
        #1;
        check("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/datapath_unit.md
Name: datapath_unit

Overview:
- Execution datapath that sits directly downstream of the instruction controller and consumes its per-cycle control word.
- Control word fields: D_wr, RF_s, RF_W_en, D_addr, RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel.
- Contains a 16-entry register file, a 16-function ALU, a synchronous data RAM and a flags register.
- Supports memory-to-register loads, register-to-memory stores and register-to-register ALU operations.

Parameters:
- WIDTH, 16, datapath/register/memory word width
- D_ADDR_W, 8, data memory address width (2**D_ADDR_W words)
- R_ADDR_W, 4, register file address width (2**R_ADDR_W registers)

Ports:
- clk  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- D_wr  in  1  data RAM write enable
- RF_s  in  1  RF write-data select: 1 = RAM read data, 0 = ALU result
- RF_W_en  in  1  register file write enable
- D_addr  in  D_ADDR_W  data RAM address
- RF_W_addr  in  R_ADDR_W  RF write address
- RF_A_addr  in  R_ADDR_W  RF read port A address
- RF_B_addr  in  R_ADDR_W  RF read port B address
- ALU_sel  in  4  ALU function select
- A_out  out  WIDTH  RF port A data (combinational)
- B_out  out  WIDTH  RF port B data (combinational)
- ALU_out  out  WIDTH  ALU result (combinational)
- Mem_out  out  WIDTH  registered RAM read data
- Flags  out  4  {Z,N,C,V}, registered

Behaviour:
- Reset (reset=1 at posedge):
  - all registers in the RF <= 0; Mem_out <= 0; Flags <= 0.
  - RF writes, RAM writes and flag updates are suppressed in that cycle.
  - RAM contents are not cleared.
- RF reads are asynchronous: A_out = RF[RF_A_addr], B_out = RF[RF_B_addr].
- No write-to-read bypass: a read of RF_W_addr in the write cycle returns the old value; the new value is visible after the edge.
- RF write at posedge when RF_W_en=1: RF[RF_W_addr] <= (RF_s ? Mem_out : ALU_out).
- RAM has synchronous, read-first behaviour:
  - each posedge, Mem_out <= RAM[D_addr].
  - if D_wr=1, RAM[D_addr] <= A_out on the same edge.
  - a simultaneous read and write to the same address returns the old word.
- Load (memory to register):
  - the controller holds D_addr for 2 cycles.
  - cycle 1: Mem_out captures RAM[D_addr].
  - cycle 2: RF_s=1, RF_W_en=1 writes it to the RF.
  - total latency: 2 edges from D_addr valid to RF update.
- Store: D_wr=1 with RF_A_addr set; RAM is updated at the next edge (1-cycle latency).
- ALU operations: combinational, A = A_out, B = B_out, result truncated to WIDTH.
  - 0: 0
  - 1: A+B
  - 2: A-B
  - 3: A
  - 4: A^B
  - 5: A|B
  - 6: A&B
  - 7: A+1
  - 8: B
  - 9: ~A
  - 10: A<<1
  - 11: A>>1 (logical)
  - 12: A>>>1 (arithmetic)
  - 13: B-A
  - 14: A-1
  - 15: 0
- Flags update at posedge only when RF_W_en=1 and RF_s=0; otherwise they hold.
  - Z = (ALU_out == 0)
  - N = ALU_out[WIDTH-1]
  - C = carry-out for ADD/A+1, NOT-borrow for SUB/B-A/A-1, shifted-out bit for shifts, 0 otherwise.
  - V = signed overflow for add/sub family, 0 otherwise.
- Wrap-around:
  - 0xFFFF+1 = 0x0000 with Z=1, C=1.
  - 0x7FFF+1 = 0x8000 with N=1, V=1.
- Simultaneous RF_W_en and D_wr are legal: the RF write and RAM write both occur and the store uses the pre-edge A_out.
- Reset asserted mid-load discards the pending Mem_out (forced to 0); no RF write occurs.

Test Plan:
- Reset: hold reset 2 cycles with RF_W_en=1, D_wr=1 -> all RF reads 0, Mem_out=0, Flags=0, RAM untouched.
- ALU/writeback: preload R1=0x0005, R2=0x0003 via loads; ALU_sel=1, RF_W_addr=3, RF_W_en=1 -> R3=0x0008, Flags=0000.
- ALU_sel=2 into R4 -> R4=0x0002, C=1.
- Store then load:
  - R1=0x1234, D_wr=1, D_addr=0x20 -> RAM[0x20]=0x1234.
  - D_addr=0x20 held 2 cycles, RF_s=1, RF_W_en on cycle 2 to R5 -> R5=0x1234 exactly 2 edges later; Flags unchanged.
- Overflow/wrap:
  - R6=0x7FFF, ALU_sel=7 -> 0x8000, Flags N=1, V=1, Z=0.
  - R7=0xFFFF, ALU_sel=7 -> 0x0000, Z=1, C=1.
- Hazards:
  - write R2 while RF_A_addr=2 -> A_out shows old value that cycle, new value next cycle.
  - D_wr and read same D_addr -> Mem_out returns old word.
- Reset mid-load: assert reset in cycle 2 of a load -> target register stays 0, Mem_out=0.
